// File: rtl/gbt_seq_pkg.sv
// Shared types and default timing for the GBT link bring-up sequencer.
package gbt_seq_pkg;

  // Clock/reset bundle of the MGMT frame-clock domain.
  typedef struct packed {
    logic clk;
    logic reset;
  } ckrs_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GEN_RST = 3'd1,
    WAIT_TX = 3'd2,
    WAIT_RX = 3'd3,
    LINK_UP = 3'd4,
    RX_RST  = 3'd5,
    BACKOFF = 3'd6,
    FAULT   = 3'd7
  } t_gbt_seq_state;

  // Defaults at 40 MHz.
  localparam int C_RESET_CYCLES   = 64;
  localparam int C_TX_TIMEOUT     = 4_000_000;  // 100 ms
  localparam int C_RX_TIMEOUT     = 4_000_000;
  localparam int C_BACKOFF_CYCLES = 400_000;    // 10 ms
  localparam int C_LOS_DEBOUNCE   = 1024;
  localparam int C_MAX_RETRIES    = 8;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/gbt_los_debounce.sv
// SFP loss-of-signal synchroniser and debouncer. The debounced level only
// moves after g_LosDebounce consecutive synchronised samples at the new level.
module gbt_los_debounce
  import gbt_seq_pkg::*;
#(
  parameter int g_LosDebounce = C_LOS_DEBOUNCE
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic los_i,
  output logic los_db_o
);

  localparam int CW = (g_LosDebounce > 1) ? $clog2(g_LosDebounce) : 1;

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          db_q, db_d;

  // Two-flop synchroniser; resets to "loss" so the link starts dark.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], los_i};
  end

  // Run-length of samples disagreeing with the debounced level.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (sync_q[1] != db_q) begin
      if (cnt_q == CW'(g_LosDebounce - 1)) db_d = sync_q[1];
      else                                 cnt_d = cnt_q + CW'(1);
    end
  end

  // Debounce state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      db_q  <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      db_q  <= db_d;
    end
  end

  assign los_db_o = db_q;

endmodule

// File: rtl/gbt_link_sequencer.sv
// Bring-up / recovery sequencer for the GBT transceiver bank and its SFP.
// All outputs are registered from the next state so they change together
// with state_o.
module gbt_link_sequencer
  import gbt_seq_pkg::*;
#(
  parameter int g_ResetCycles   = C_RESET_CYCLES,
  parameter int g_TxTimeout     = C_TX_TIMEOUT,
  parameter int g_RxTimeout     = C_RX_TIMEOUT,
  parameter int g_BackoffCycles = C_BACKOFF_CYCLES,
  parameter int g_LosDebounce   = C_LOS_DEBOUNCE,
  parameter int g_MaxRetries    = C_MAX_RETRIES
) (
  input  ckrs_t       ClkRs_ix,
  input  logic        enable_i,
  input  logic        sfp_los_i,
  input  logic        gbttx_ready_i,
  input  logic        gbtrx_ready_i,
  input  logic        rxready_lost_flag_i,
  output logic        general_reset_o,
  output logic        manual_reset_tx_o,
  output logic        manual_reset_rx_o,
  output logic        reset_lost_flag_o,
  output logic        sfp_txdisable_o,
  output logic        link_up_o,
  output logic        fault_o,
  output logic [7:0]  retry_cnt_o,
  output logic [2:0]  state_o
);

  localparam int TMAX = max2(max2(g_ResetCycles, g_BackoffCycles),
                             max2(g_TxTimeout, g_RxTimeout));
  localparam int TW   = $clog2(TMAX + 1);

  logic clk, rst;
  assign clk = ClkRs_ix.clk;
  assign rst = ClkRs_ix.reset;

  t_gbt_seq_state state_q, state_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [7:0]     retry_q, retry_d;
  logic           los_db;
  logic           gen_q, gen_d, txd_q, txd_d, rxr_q, rxr_d;
  logic           lu_q, lu_d, flt_q, flt_d;

  gbt_los_debounce #(.g_LosDebounce(g_LosDebounce)) u_los (
    .clk_i    (clk),
    .rst_i    (rst),
    .los_i    (sfp_los_i),
    .los_db_o (los_db)
  );

  // Dwell length for the state being entered; the timer counts it down to 0.
  function automatic logic [TW-1:0] reload(input t_gbt_seq_state s);
    case (s)
      GEN_RST, RX_RST: return TW'(g_ResetCycles - 1);
      WAIT_TX:         return TW'(g_TxTimeout - 1);
      WAIT_RX:         return TW'(g_RxTimeout - 1);
      BACKOFF:         return TW'(g_BackoffCycles - 1);
      default:         return '0;
    endcase
  endfunction

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: enable, then LOS, then per-state progress (ready beats timeout).
  always_comb begin
    state_d = state_q;
    if (!enable_i) begin
      state_d = IDLE;
    end else if (los_db && state_q != IDLE && state_q != FAULT) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (!los_db) state_d = GEN_RST;
        GEN_RST: if (timer_q == '0) state_d = WAIT_TX;
        WAIT_TX: if (gbttx_ready_i)       state_d = WAIT_RX;
                 else if (timer_q == '0)  state_d = BACKOFF;
        WAIT_RX: if (gbtrx_ready_i && !rxready_lost_flag_i) state_d = LINK_UP;
                 else if (timer_q == '0)                    state_d = BACKOFF;
        LINK_UP: if (!gbttx_ready_i)                              state_d = BACKOFF;
                 else if (!gbtrx_ready_i || rxready_lost_flag_i)  state_d = RX_RST;
        RX_RST:  if (timer_q == '0) state_d = WAIT_RX;
        BACKOFF: if (retry_q >= 8'(g_MaxRetries)) state_d = FAULT;
                 else if (timer_q == '0)          state_d = GEN_RST;
        FAULT:   state_d = FAULT;
        default: state_d = IDLE;
      endcase
    end
  end

  // Timer reload on any transition; retry count bumps on BACKOFF entry and
  // clears on LINK_UP entry or whenever the link is disabled (also leaving FAULT).
  always_comb begin
    if (state_d != state_q)  timer_d = reload(state_d);
    else if (timer_q != '0)  timer_d = timer_q - TW'(1);
    else                     timer_d = timer_q;

    retry_d = retry_q;
    if (!enable_i) begin
      retry_d = '0;
    end else if (state_d != state_q) begin
      if (state_d == LINK_UP)                    retry_d = '0;
      else if (state_d == BACKOFF && retry_q != 8'hFF) retry_d = retry_q + 8'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q <= '0;
      retry_q <= '0;
    end else begin
      timer_q <= timer_d;
      retry_q <= retry_d;
    end
  end

  // Output decode from the next state.
  always_comb begin
    gen_d = (state_d == IDLE) || (state_d == GEN_RST) || (state_d == FAULT);
    txd_d = (state_d == IDLE) || (state_d == BACKOFF) || (state_d == FAULT);
    rxr_d = (state_d == RX_RST);
    lu_d  = (state_d == LINK_UP);
    flt_d = (state_d == FAULT);
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gen_q <= 1'b1;
      txd_q <= 1'b1;
      rxr_q <= 1'b0;
      lu_q  <= 1'b0;
      flt_q <= 1'b0;
    end else begin
      gen_q <= gen_d;
      txd_q <= txd_d;
      rxr_q <= rxr_d;
      lu_q  <= lu_d;
      flt_q <= flt_d;
    end
  end

  assign general_reset_o   = gen_q;
  assign manual_reset_tx_o = 1'b0;
  assign manual_reset_rx_o = rxr_q;
  assign reset_lost_flag_o = rxr_q;
  assign sfp_txdisable_o   = txd_q;
  assign link_up_o         = lu_q;
  assign fault_o           = flt_q;
  assign retry_cnt_o       = retry_q;
  assign state_o           = state_q;

endmodule

// File: tb/tb_gbt_link_sequencer.sv
// Directed scenarios plus a random soak for gbt_link_sequencer, checked every
// cycle against a dwell-time / sample-window reference model.
module tb_gbt_link_sequencer;
  import gbt_seq_pkg::*;

  localparam int R   = 4;
  localparam int TXT = 100;
  localparam int RXT = 100;
  localparam int B   = 10;
  localparam int D   = 4;
  localparam int M   = 3;

  logic clk = 1'b0, rst = 1'b1;
  logic en = 1'b0, los = 1'b1, tx = 1'b0, rx = 1'b0, lost = 1'b0;
  ckrs_t ckrs;
  logic gen_o, mtx_o, mrx_o, rlf_o, txd_o, lu_o, flt_o;
  logic [7:0] retry_o;
  logic [2:0] state_o;

  assign ckrs = {clk, rst};
  always #5 clk = ~clk;

  gbt_link_sequencer #(
    .g_ResetCycles(R), .g_TxTimeout(TXT), .g_RxTimeout(RXT),
    .g_BackoffCycles(B), .g_LosDebounce(D), .g_MaxRetries(M)
  ) dut (
    .ClkRs_ix(ckrs), .enable_i(en), .sfp_los_i(los),
    .gbttx_ready_i(tx), .gbtrx_ready_i(rx), .rxready_lost_flag_i(lost),
    .general_reset_o(gen_o), .manual_reset_tx_o(mtx_o),
    .manual_reset_rx_o(mrx_o), .reset_lost_flag_o(rlf_o),
    .sfp_txdisable_o(txd_o), .link_up_o(lu_o), .fault_o(flt_o),
    .retry_cnt_o(retry_o), .state_o(state_o)
  );

  int n_assert = 0, n_fail = 0, cyc = 0;

  // ---------------- reference model ----------------
  t_gbt_seq_state mst;
  int  mdwell, mretry;
  bit  ms1, ms2, mdb;
  bit  hist[$];

  task automatic model_reset();
    mst = IDLE; mdwell = 0; mretry = 0;
    ms1 = 1'b1; ms2 = 1'b1; mdb = 1'b1;
    hist = {};
    for (int i = 0; i < D; i++) hist.push_back(1'b1);
  endtask

  task automatic model_step();
    t_gbt_seq_state nst;
    bit db_old, all_same;
    if (rst) begin model_reset(); return; end
    db_old = mdb;
    // LOS: the debounced level follows once the last D synced samples agree
    hist.push_back(ms2);
    void'(hist.pop_front());
    all_same = 1'b1;
    foreach (hist[i]) if (hist[i] != hist[0]) all_same = 1'b0;
    if (all_same) mdb = hist[0];
    ms2 = ms1; ms1 = los;
    // sequencer
    nst = mst;
    if (!en) begin
      nst = IDLE; mretry = 0;
    end else if (db_old && mst != IDLE && mst != FAULT) begin
      nst = IDLE;
    end else begin
      case (mst)
        IDLE:    if (!db_old) nst = GEN_RST;
        GEN_RST: if (mdwell + 1 == R) nst = WAIT_TX;
        WAIT_TX: if (tx) nst = WAIT_RX; else if (mdwell + 1 == TXT) nst = BACKOFF;
        WAIT_RX: if (rx && !lost) nst = LINK_UP; else if (mdwell + 1 == RXT) nst = BACKOFF;
        LINK_UP: if (!tx) nst = BACKOFF; else if (!rx || lost) nst = RX_RST;
        RX_RST:  if (mdwell + 1 == R) nst = WAIT_RX;
        BACKOFF: if (mretry >= M) nst = FAULT; else if (mdwell + 1 == B) nst = GEN_RST;
        default: nst = mst;
      endcase
      if (nst == LINK_UP && mst != LINK_UP) mretry = 0;
      if (nst == BACKOFF && mst != BACKOFF) mretry = (mretry < 255) ? mretry + 1 : 255;
    end
    mdwell = (nst == mst) ? mdwell + 1 : 0;
    mst = nst;
  endtask

  function automatic logic [17:0] model_vec();
    logic g, t, r, l, f;
    g = (mst == IDLE) || (mst == GEN_RST) || (mst == FAULT);
    t = (mst == IDLE) || (mst == BACKOFF) || (mst == FAULT);
    r = (mst == RX_RST);
    l = (mst == LINK_UP);
    f = (mst == FAULT);
    return {g, 1'b0, r, r, t, l, f, 8'(mretry), 3'(mst)};
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  int gr_cnt, rxr_cnt, bo_entries, wtx_run;
  bit txd_seen;
  int wtx_runs[$];
  logic [2:0] prev_state;

  task automatic observe();
    logic [17:0] obs;
    obs = {gen_o, mtx_o, mrx_o, rlf_o, txd_o, lu_o, flt_o, retry_o, state_o};
    check("outputs", 32'(obs), 32'(model_vec()));
    if (gen_o && state_o == GEN_RST) gr_cnt++;
    if (mrx_o) rxr_cnt++;
    if (txd_o) txd_seen = 1'b1;
    if (state_o == BACKOFF && prev_state != BACKOFF) bo_entries++;
    if (state_o == WAIT_TX) wtx_run++;
    else if (prev_state == WAIT_TX) begin wtx_runs.push_back(wtx_run); wtx_run = 0; end
    prev_state = state_o;
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_step();
    #1;
    observe();
  endtask

  task automatic run_to(input t_gbt_seq_state s, input int bound, input string tag);
    int k;
    k = 0;
    while (mst != s && k < bound) begin tick(); k++; end
    check({tag, "_reached"}, 32'(mst == s), 32'd1);
  endtask

  initial begin
    int k;
    model_reset();
    prev_state = 3'd0; wtx_run = 0;
    repeat (2) tick();
    rst = 1'b0;

    // 1. nominal bring-up
    en = 1'b1; los = 1'b0; gr_cnt = 0;
    run_to(WAIT_TX, 40, "s1_wait_tx");
    repeat (4) tick();
    tx = 1'b1;
    run_to(WAIT_RX, 5, "s1_wait_rx");
    repeat (9) tick();
    rx = 1'b1;
    repeat (2) tick();
    check("s1_genrst_len", 32'(gr_cnt), R);
    check("s1_link_up", 32'(lu_o), 1);
    check("s1_retry", 32'(retry_o), 0);

    // 3. RX-ready-lost pulse in LINK_UP
    rxr_cnt = 0; txd_seen = 1'b0;
    lost = 1'b1; tick(); lost = 1'b0;
    run_to(LINK_UP, 20, "s3_relink");
    tick();
    check("s3_rxrst_len", 32'(rxr_cnt), R);
    check("s3_retry", 32'(retry_o), 0);
    check("s3_txdis_low", 32'(txd_seen), 0);

    // 4. LOS glitch, then real loss and recovery
    los = 1'b1; repeat (3) tick(); los = 1'b0;
    repeat (8) tick();
    check("s4_glitch_ignored", 32'(lu_o), 1);
    los = 1'b1;
    run_to(IDLE, 20, "s4_loss");
    check("s4_txdis", 32'(txd_o), 1);
    check("s4_link_down", 32'(lu_o), 0);
    los = 1'b0;
    run_to(GEN_RST, 20, "s4_restart");
    check("s4_state_genrst", 32'(state_o), 32'(GEN_RST));
    run_to(LINK_UP, 40, "s4_relink");

    // 6. tx_ready arriving on the timeout clock wins
    tx = 1'b0; rx = 1'b0; tick();
    k = 0;
    while (!(mst == WAIT_TX && mdwell == TXT - 1) && k < 300) begin tick(); k++; end
    check("s6_at_timeout", 32'(mst == WAIT_TX && mdwell == TXT - 1), 1);
    tx = 1'b1; tick();
    check("s6_state", 32'(state_o), 32'(WAIT_RX));
    check("s6_retry", 32'(retry_o), 1);
    rx = 1'b1;
    run_to(LINK_UP, 5, "s6_link");

    // 2. TX timeouts until FAULT, then clear via enable
    en = 1'b0; tick();
    tx = 1'b0; rx = 1'b0; en = 1'b1;
    bo_entries = 0; wtx_runs = {}; wtx_run = 0;
    run_to(FAULT, 1000, "s2_fault");
    tick();
    check("s2_backoffs", 32'(bo_entries), 3);
    check("s2_wtx_runs", 32'(wtx_runs.size()), 3);
    foreach (wtx_runs[i]) check("s2_wtx_len", 32'(wtx_runs[i]), TXT);
    check("s2_fault_o", 32'(flt_o), 1);
    check("s2_retry", 32'(retry_o), 3);
    repeat (5) tick();
    check("s2_sticky", 32'(flt_o), 1);
    en = 1'b0; tick(); en = 1'b1;
    check("s2_idle", 32'(state_o), 32'(IDLE));
    check("s2_retry_clr", 32'(retry_o), 0);

    // 5. async reset in the middle of GEN_RST
    tx = 1'b1; rx = 1'b1;
    run_to(GEN_RST, 10, "s5_genrst");
    tick();
    #3 rst = 1'b1;
    #1;
    check("s5_async_outs",
          32'({gen_o, mtx_o, mrx_o, rlf_o, txd_o, lu_o, flt_o, retry_o, state_o}),
          32'({1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 3'd0}));
    model_reset();
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check("s5_held_idle", 32'(state_o), 32'(IDLE));
    run_to(LINK_UP, 40, "s5_relink");

    // random soak
    for (int i = 0; i < 3000; i++) begin
      en   = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 149) == 0) los = ~los;
      tx   = ($urandom_range(0, 99) != 0);
      rx   = ($urandom_range(0, 59) != 0);
      lost = ($urandom_range(0, 99) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
